mac_dot_ctrl: RTL and testbench



---
 rtl/mac_pkg.sv | 35 +++
 rtl/mac_dot_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mac_dot_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the dot-product job sequencer (mac_dot_ctrl) and the
// pipelined 4x4 multiply-accumulate unit it drives.
//   state_t      : sequencer FSM states
//   MAC_LAT      : cycles from MAC en sample to the accumulate edge
//   DRAIN_CYC    : drain wait after the last registered pair (MAC_LAT + 2)
//   ACC_W/DATA_W : accumulator and operand widths
//   MAX_LEN_W    : widest job length that cannot overflow the accumulator
// -----------------------------------------------------------------------------
package mac_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      FEED  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int DATA_W    = 4;
   localparam int ACC_W     = 16;
   localparam int MAC_LAT   = 3;
   // 255 * 15 * 15 = 57375 still fits in ACC_W bits; 511 pairs would not.
   localparam int MAX_LEN_W = 8;

   // One cycle for the registered mac_en to reach the MAC, MAC_LAT cycles of
   // pipeline, and one more so mac_out is stable before it is captured.
   function automatic int drain_cycles(input int lat);
      return lat + 2;
   endfunction

   localparam int DRAIN_CYC = drain_cycles(MAC_LAT);

endpackage

// File: rtl/mac_dot_ctrl.sv
// -----------------------------------------------------------------------------
// mac_dot_ctrl
// Job-level sequencer for one mac_4x4. A job of `len` operand pairs clears the
// MAC accumulator, streams the pairs into the MAC, waits for the multiplier
// pipeline to drain and then offers the 16-bit accumulator value as a result.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   start, len         : job request and pair count (sampled only in IDLE)
//   busy               : high in every state except IDLE
//   in_valid/in_ready  : operand stream handshake, in_a/in_b operands
//   mac_clr, mac_en    : MAC clear (to MAC rst) and enable
//   mac_a, mac_b       : MAC operands
//   mac_out            : MAC accumulator value
//   res_valid/res_ready: result handshake, res_data result
//   dbg_state          : current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The source keeps valid and its payload stable until that
// edge; ready may be high without valid. Here in_ready and res_valid are
// registered and never depend combinationally on in_valid or res_ready.
//
// Every MAC-facing output is registered, so there is no path from any input
// to the MAC ports inside one cycle.
// -----------------------------------------------------------------------------
module mac_dot_ctrl
   import mac_pkg::*;
#(
   parameter int LEN_W   = 8,
   parameter int MAC_LAT = mac_pkg::MAC_LAT,
   parameter int DATA_W  = mac_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   output logic              mac_clr,
   output logic              mac_en,
   output logic [DATA_W-1:0] mac_a,
   output logic [DATA_W-1:0] mac_b,
   input  logic [ACC_W-1:0]  mac_out,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ACC_W-1:0]  res_data,
   output state_t            dbg_state
);

   localparam int DRAIN_N = drain_cycles(MAC_LAT);
   localparam int CNT_W   = $clog2(DRAIN_N + 1);
   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_N);

   // Wider jobs could overflow the accumulator; refuse to elaborate.
   if (LEN_W > MAX_LEN_W) begin : g_len_w_too_wide
      $error("mac_dot_ctrl: LEN_W must not exceed %0d", MAX_LEN_W);
   end
   if (MAC_LAT < 1) begin : g_mac_lat_invalid
      $error("mac_dot_ctrl: MAC_LAT must be at least 1");
   end

   state_t              state_q;
   logic [LEN_W-1:0]    rem_q;
   logic [CNT_W-1:0]    drain_q;
   logic                busy_q;
   logic                in_ready_q;
   logic                mac_clr_q;
   logic                mac_en_q;
   logic [DATA_W-1:0]   mac_a_q;
   logic [DATA_W-1:0]   mac_b_q;
   logic                res_valid_q;
   logic [ACC_W-1:0]    res_data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         drain_q     <= '0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         mac_clr_q   <= 1'b0;
         mac_en_q    <= 1'b0;
         mac_a_q     <= '0;
         mac_b_q     <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         // Single-cycle pulses; only the states below raise them.
         mac_clr_q <= 1'b0;
         mac_en_q  <= 1'b0;

         case (state_q)
            IDLE: begin
               if (start) begin
                  rem_q     <= len;
                  busy_q    <= 1'b1;
                  mac_clr_q <= 1'b1;
                  state_q   <= CLEAR;
               end
            end

            CLEAR: begin
               if (rem_q != '0) begin
                  in_ready_q <= 1'b1;
                  state_q    <= FEED;
               end else begin
                  drain_q <= DRAIN_LOAD;
                  state_q <= DRAIN;
               end
            end

            FEED: begin
               // in_ready_q is high throughout FEED. Without a transfer the
               // MAC sees a bubble and mac_a/mac_b simply hold.
               if (in_valid && in_ready_q) begin
                  mac_en_q <= 1'b1;
                  mac_a_q  <= in_a;
                  mac_b_q  <= in_b;
                  rem_q    <= rem_q - LEN_W'(1);
                  if (rem_q == LEN_W'(1)) begin
                     in_ready_q <= 1'b0;
                     drain_q    <= DRAIN_LOAD;
                     state_q    <= DRAIN;
                  end
               end
            end

            DRAIN: begin
               drain_q <= drain_q - CNT_W'(1);
               // By now the final product has reached the accumulator.
               if (drain_q == CNT_W'(1)) begin
                  res_data_q  <= mac_out;
                  res_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end

            DONE: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end

            default: begin
               in_ready_q  <= 1'b0;
               res_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign in_ready  = in_ready_q;
   assign mac_clr   = mac_clr_q;
   assign mac_en    = mac_en_q;
   assign mac_a     = mac_a_q;
   assign mac_b     = mac_b_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mac_dot_ctrl
// Directed bench for mac_dot_ctrl. A small behavioural mac_4x4 stand-in
// (three pipeline stages, accumulate on the third edge after en is sampled,
// cleared by rst | mac_clr) closes the loop so real dot products come back.
// -----------------------------------------------------------------------------
module tb_mac_dot_ctrl;
   import mac_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic        start;
   logic [7:0]  len;
   logic        busy;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_a;
   logic [3:0]  in_b;
   logic        mac_clr;
   logic        mac_en;
   logic [3:0]  mac_a;
   logic [3:0]  mac_b;
   logic [15:0] mac_out;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   state_t      dbg_state;

   mac_dot_ctrl #(.LEN_W(8), .MAC_LAT(3), .DATA_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .mac_clr   (mac_clr),
      .mac_en    (mac_en),
      .mac_a     (mac_a),
      .mac_b     (mac_b),
      .mac_out   (mac_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .dbg_state (dbg_state)
   );

   // ---------------- MAC stand-in ----------------
   logic       s1_v, s2_v, s3_v;
   logic [7:0] s1_p, s2_p, s3_p;
   logic [15:0] acc;
   int unsigned en_cnt = 0;

   always @(posedge clk) begin
      if (mac_en) en_cnt <= en_cnt + 1;
      if (rst || mac_clr) begin
         s1_v <= 1'b0; s2_v <= 1'b0; s3_v <= 1'b0;
         s1_p <= '0;   s2_p <= '0;   s3_p <= '0;
         acc  <= '0;
      end else begin
         s1_v <= mac_en; s1_p <= mac_a * mac_b;
         s2_v <= s1_v;   s2_p <= s1_p;
         s3_v <= s2_v;   s3_p <= s2_p;
         if (s3_v) acc <= acc + 16'(s3_p);
      end
   end
   assign mac_out = acc;

   // ---------------- scoreboard counters ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one edge; afterwards the DUT is in CLEAR.
   task automatic start_job(input logic [7:0] n);
      start = 1'b1;
      len   = n;
      step();
      start = 1'b0;
      check("busy_after_start", busy, 1);
      check("clr_after_start", mac_clr, 1);
   endtask

   // Offer one pair and return just after the edge that transfers it.
   task automatic send_pair(input logic [3:0] a, input logic [3:0] b);
      int k;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      k = 0;
      while (!in_ready && k < 20) begin
         step();
         k++;
      end
      check("in_ready_wait", in_ready, 1);
      step();
      in_valid = 1'b0;
   endtask

   // Count edges until res_valid rises (bounded).
   task automatic wait_valid(output int n);
      n = 0;
      while (!res_valid && n < 50) begin
         step();
         n++;
      end
   endtask

   task automatic accept_result();
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check("idle_after_accept", 32'(dbg_state), 32'(IDLE));
      check("valid_drop", res_valid, 0);
      check("busy_drop", busy, 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      int unsigned en0;
      rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
      in_a = '0; in_b = '0; res_ready = 1'b0;
      step();
      step();
      rst = 1'b0;

      // Reset state
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_mac_en", mac_en, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 0);
      step();

      // Back-to-back job: 2*3 + 4*5 + 15*15 = 251
      start_job(8'd3);
      check("clear_in_ready", in_ready, 0);
      send_pair(4'd2, 4'd3);
      send_pair(4'd4, 4'd5);
      send_pair(4'd15, 4'd15);
      check("drain_in_ready", in_ready, 0);
      wait_valid(n);
      check("b2b_latency", n, 5);
      check("b2b_data", res_data, 16'h00FB);
      accept_result();

      // Empty job
      en0 = en_cnt;
      start_job(8'd0);
      wait_valid(n);
      check("empty_latency", n, 6);
      check("empty_data", res_data, 0);
      check("empty_en_pulses", en_cnt - en0, 0);
      accept_result();

      // Maximum job: 255 * 225 = 57375
      en0 = en_cnt;
      start_job(8'd255);
      for (int i = 0; i < 255; i++) send_pair(4'd15, 4'd15);
      wait_valid(n);
      check("max_latency", n, 5);
      check("max_data", res_data, 16'hE01F);
      check("max_en_pulses", en_cnt - en0, 255);
      accept_result();

      // Bubbles, ignored start and result backpressure: 1+4+9+16 = 30
      start_job(8'd4);
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b0;
         if (i == 2) begin
            start = 1'b1;
            len   = 8'd9;
         end
         step();
         start = 1'b0;
         check("bubble_mac_en", mac_en, 0);
         send_pair(4'(i), 4'(i));
      end
      wait_valid(n);
      check("bub_latency", n, 5);
      start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         start = 1'b0;
         check("stall_state", 32'(dbg_state), 32'(DONE));
         check("stall_valid", res_valid, 1);
         check("stall_data", res_data, 30);
      end
      accept_result();

      // Follow-up job proves the accumulator was cleared: 5*6 = 30
      start_job(8'd1);
      send_pair(4'd5, 4'd6);
      wait_valid(n);
      check("clear_proof_data", res_data, 30);
      accept_result();

      // Reset in the middle of FEED
      start_job(8'd4);
      send_pair(4'd3, 4'd3);
      send_pair(4'd2, 4'd2);
      check("pre_rst_mac_en", mac_en, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
      check("mid_rst_busy", busy, 0);
      check("mid_rst_in_ready", in_ready, 0);
      check("mid_rst_mac_clr", mac_clr, 0);
      check("mid_rst_mac_en", mac_en, 0);
      check("mid_rst_mac_a", mac_a, 0);
      check("mid_rst_mac_b", mac_b, 0);
      check("mid_rst_res_valid", res_valid, 0);
      check("mid_rst_res_data", res_data, 0);
      start_job(8'd1);
      send_pair(4'd7, 4'd7);
      wait_valid(n);
      check("post_rst_data", res_data, 49);
      accept_result();

      // Result accepted on the DONE entry cycle, new start in the next IDLE
      start_job(8'd1);
      send_pair(4'd9, 4'd2);
      res_ready = 1'b1;
      wait_valid(n);
      check("fast_data", res_data, 18);
      step();
      res_ready = 1'b0;
      check("fast_idle", 32'(dbg_state), 32'(IDLE));
      check("fast_valid_drop", res_valid, 0);
      start_job(8'd2);
      check("fast_restart_state", 32'(dbg_state), 32'(CLEAR));
      send_pair(4'd1, 4'd2);
      send_pair(4'd3, 4'd4);
      wait_valid(n);
      check("fast_restart_latency", n, 5);
      check("fast_restart_data", res_data, 14);
      accept_result();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time limit as a backstop for any unbounded stall.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
